// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the IF->ID->EX pipeline control blocks.
package rv32_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Hazard controller FSM: normal issue, or inside a post-jump flush window.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for x1..x31, with same-cycle writeback bypass
// on the three lookups used by the hazard check.
module reg_scoreboard
  import rv32_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs1_pend,
  output logic                  rs2_pend,
  output logic                  rd_pend,
  output logic [NUM_REGS-1:0]   pending
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] eff_pending;
  logic [NUM_REGS-1:0] pending_next;

  // Decode the retiring writeback into a clear mask (kept apart from the set
  // path so the lookup never depends on the issue decision).
  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // Decode the newly issued writer into a set mask.
  always_comb begin
    set_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
  end

  // A register being written back this cycle is forwarded by the regfile,
  // so it no longer counts as pending for the hazard lookups.
  assign eff_pending = pending & ~clr_mask;
  assign rs1_pend    = eff_pending[rs1_addr];
  assign rs2_pend    = eff_pending[rs2_addr];
  assign rd_pend     = eff_pending[rd_addr];

  // Set wins over clear so a new writer to a retiring register stays tracked;
  // x0 is never tracked.
  always_comb begin
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Issue/stall/flush controller sitting beside the decoder: tracks in-flight
// register writes, stalls on RAW/WAW or a full write window, and sequences
// the flush after a taken jump resolved in EX.
module pipe_hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_shamt,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  input  logic                  i_rd_we,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
  input  logic                  i_ex_jump_flag,
  output logic                  o_issue,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic [NUM_REGS-1:0]   o_pending,
  output logic [3:0]            o_inflight
);

  // The flush counter holds the cycles remaining after the next one.
  localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [2:0] CNT_LOAD    = MULTI_FLUSH ? 3'(FLUSH_CYCLES - 2) : 3'd0;
  localparam logic [3:0] MAX_CNT     = 4'(MAX_INFLIGHT);

  hz_state_e  state, next_state;
  logic [2:0] cnt, next_cnt;
  logic [3:0] inflight;

  logic rs1_pend, rs2_pend, rd_pend;
  logic hazard, full;
  logic issue, stall, flush;
  logic set_en, wb_dec;

  reg_scoreboard u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .set_en   (set_en),
    .set_addr (i_rd_addr),
    .clr_en   (i_wb_valid),
    .clr_addr (i_wb_rd_addr),
    .rs1_addr (i_rs1_addr),
    .rs2_addr (i_rs2_addr_shamt),
    .rd_addr  (i_rd_addr),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend),
    .pending  (o_pending)
  );

  // RAW on either used source, or WAW on the destination.
  assign hazard = (i_rs1_used & (i_rs1_addr != '0) & rs1_pend)
                | (i_rs2_used & (i_rs2_addr_shamt != '0) & rs2_pend)
                | (i_rd_we & (i_rd_addr != '0) & rd_pend);

  // A writeback this cycle frees a slot for the next writer.
  assign full = (inflight == MAX_CNT) & ~i_wb_valid;

  // FSM next state and control outputs; jump takes priority over stall/issue.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    issue      = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    case (state)
      RUN: begin
        flush = i_ex_jump_flag;
        stall = i_id_valid & ~i_ex_jump_flag & (hazard | (full & i_rd_we));
        issue = i_id_valid & ~i_ex_jump_flag & ~stall;
        if (i_ex_jump_flag && MULTI_FLUSH) begin
          next_state = FLUSH;
          next_cnt   = CNT_LOAD;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (i_ex_jump_flag)  next_cnt   = CNT_LOAD;
        else if (cnt == '0)  next_state = RUN;
        else                 next_cnt   = cnt - 3'd1;
      end
    endcase
  end

  // Controls read as idle whenever reset is asserted, independent of inputs.
  assign o_issue    = issue & i_rst_n;
  assign o_stall    = stall & i_rst_n;
  assign o_flush    = flush & i_rst_n;
  assign o_inflight = inflight;

  assign set_en = o_issue & i_rd_we & (i_rd_addr != '0);
  assign wb_dec = i_wb_valid & (i_wb_rd_addr != '0) & (inflight != '0);

  // FSM state and flush counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // In-flight write counter; simultaneous issue and retire cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight <= '0;
    end else begin
      case ({set_en, wb_dec})
        2'b10:   inflight <= inflight + 4'd1;
        2'b01:   inflight <= inflight - 4'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MAX_INFLIGHT=4).
module tb_pipe_hazard_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_id_valid;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr_shamt;
  logic        i_rs1_used;
  logic        i_rs2_used;
  logic [4:0]  i_rd_addr;
  logic        i_rd_we;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd_addr;
  logic        i_ex_jump_flag;
  logic        o_issue;
  logic        o_stall;
  logic        o_flush;
  logic [31:0] o_pending;
  logic [3:0]  o_inflight;

  int vectors    = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MAX_INFLIGHT(4)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_id_valid       (i_id_valid),
    .i_rs1_addr       (i_rs1_addr),
    .i_rs2_addr_shamt (i_rs2_addr_shamt),
    .i_rs1_used       (i_rs1_used),
    .i_rs2_used       (i_rs2_used),
    .i_rd_addr        (i_rd_addr),
    .i_rd_we          (i_rd_we),
    .i_wb_valid       (i_wb_valid),
    .i_wb_rd_addr     (i_wb_rd_addr),
    .i_ex_jump_flag   (i_ex_jump_flag),
    .o_issue          (o_issue),
    .o_stall          (o_stall),
    .o_flush          (o_flush),
    .o_pending        (o_pending),
    .o_inflight       (o_inflight)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 i_clk = ~i_clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    i_id_valid       = 1'b0;
    i_rs1_addr       = '0;
    i_rs2_addr_shamt = '0;
    i_rs1_used       = 1'b0;
    i_rs2_used       = 1'b0;
    i_rd_addr        = '0;
    i_rd_we          = 1'b0;
    i_wb_valid       = 1'b0;
    i_wb_rd_addr     = '0;
    i_ex_jump_flag   = 1'b0;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [4:0] rs1, input logic rs1_used,
                                input logic [4:0] rs2, input logic rs2_used,
                                input logic [4:0] rd, input logic rd_we);
    i_id_valid       = valid;
    i_rs1_addr       = rs1;
    i_rs1_used       = rs1_used;
    i_rs2_addr_shamt = rs2;
    i_rs2_used       = rs2_used;
    i_rd_addr        = rd;
    i_rd_we          = rd_we;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    i_rst_n = 1'b0;

    // Reset state
    #2;
    check_output("rst_issue",    32'(o_issue),    32'd0);
    check_output("rst_stall",    32'(o_stall),    32'd0);
    check_output("rst_flush",    32'(o_flush),    32'd0);
    check_output("rst_pending",  o_pending,       32'd0);
    check_output("rst_inflight", 32'(o_inflight), 32'd0);
    #10 i_rst_n = 1'b1;
    tick();

    // RAW stall on x5, released by same-cycle writeback
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #1 check_output("raw_first_issue", 32'(o_issue), 32'd1);
    tick();
    check_output("raw_pending5", o_pending, 32'h0000_0020);
    check_output("raw_inflight1", 32'(o_inflight), 32'd1);
    apply_stimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check_output("raw_stall", 32'(o_stall), 32'd1);
    check_output("raw_no_issue", 32'(o_issue), 32'd0);
    tick();
    check_output("raw_still_stall", 32'(o_stall), 32'd1);
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd5;
    #1;
    check_output("raw_wb_stall", 32'(o_stall), 32'd0);
    check_output("raw_wb_issue", 32'(o_issue), 32'd1);
    tick();
    idle_inputs();
    #1;
    check_output("raw_cleared", o_pending, 32'd0);
    check_output("raw_inflight0", 32'(o_inflight), 32'd0);

    // x0 destination is never tracked
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    #1 check_output("x0_issue", 32'(o_issue), 32'd1);
    tick();
    check_output("x0_pending", o_pending, 32'd0);
    check_output("x0_inflight", 32'(o_inflight), 32'd0);

    // Unused rs2 operand does not cause a stall
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    check_output("x7_pending", o_pending, 32'h0000_0080);
    apply_stimulus(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    #1;
    check_output("rs2_unused_stall", 32'(o_stall), 32'd0);
    check_output("rs2_unused_issue", 32'(o_issue), 32'd1);
    i_rs2_used = 1'b1;
    #1 check_output("rs2_used_stall", 32'(o_stall), 32'd1);
    idle_inputs();
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd7;
    tick();
    idle_inputs();
    #1 check_output("x7_cleared", o_pending, 32'd0);

    // Single jump: flush in N and N+1, gone in N+2
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    i_ex_jump_flag = 1'b1;
    #1;
    check_output("jmp_n_flush", 32'(o_flush), 32'd1);
    check_output("jmp_n_issue", 32'(o_issue), 32'd0);
    tick();
    i_ex_jump_flag = 1'b0;
    #1;
    check_output("jmp_n1_flush", 32'(o_flush), 32'd1);
    check_output("jmp_n1_issue", 32'(o_issue), 32'd0);
    check_output("jmp_n1_stall", 32'(o_stall), 32'd0);
    tick();
    check_output("jmp_n2_flush", 32'(o_flush), 32'd0);
    check_output("jmp_n2_issue", 32'(o_issue), 32'd1);

    // Second jump in N+1 extends the flush through N+2
    i_ex_jump_flag = 1'b1;
    tick();
    check_output("jmp2_n1_flush", 32'(o_flush), 32'd1);
    tick();
    i_ex_jump_flag = 1'b0;
    #1;
    check_output("jmp2_n2_flush", 32'(o_flush), 32'd1);
    check_output("jmp2_n2_issue", 32'(o_issue), 32'd0);
    tick();
    check_output("jmp2_n3_flush", 32'(o_flush), 32'd0);
    idle_inputs();

    // In-flight limit: four writers x1..x4
    for (int r = 1; r <= 4; r++) begin
      apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
      #1 check_output($sformatf("lim_issue_x%0d", r), 32'(o_issue), 32'd1);
      tick();
    end
    check_output("lim_inflight4", 32'(o_inflight), 32'd4);
    check_output("lim_pending", o_pending, 32'h0000_001E);
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    check_output("lim_5th_stall", 32'(o_stall), 32'd1);
    check_output("lim_5th_issue", 32'(o_issue), 32'd0);
    apply_stimulus(1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    check_output("lim_store_stall", 32'(o_stall), 32'd0);
    check_output("lim_store_issue", 32'(o_issue), 32'd1);
    apply_stimulus(1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0);
    #1 check_output("lim_store_raw", 32'(o_stall), 32'd1);
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd1;
    #1 check_output("lim_wb_issue", 32'(o_issue), 32'd1);
    tick();
    idle_inputs();
    #1;
    check_output("lim_wb_inflight", 32'(o_inflight), 32'd4);
    check_output("lim_wb_pending", o_pending, 32'h0000_003C);

    // Drain x2..x5
    for (int r = 2; r <= 5; r++) begin
      i_wb_valid = 1'b1; i_wb_rd_addr = 5'(r);
      tick();
    end
    idle_inputs();
    #1;
    check_output("drain_pending", o_pending, 32'd0);
    check_output("drain_inflight", 32'(o_inflight), 32'd0);

    // Set/clear collision on x9
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    check_output("col_pending", o_pending, 32'h0000_0200);
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd9;
    #1 check_output("col_issue", 32'(o_issue), 32'd1);
    tick();
    idle_inputs();
    #1;
    check_output("col_pending_kept", o_pending, 32'h0000_0200);
    check_output("col_inflight", 32'(o_inflight), 32'd1);
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd9;
    tick();
    idle_inputs();

    // Async reset in FLUSH with three pending writes
    for (int r = 10; r <= 12; r++) begin
      apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1);
      tick();
    end
    idle_inputs();
    i_ex_jump_flag = 1'b1;
    tick();
    i_ex_jump_flag = 1'b0;
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1);
    #1;
    check_output("ar_pre_flush", 32'(o_flush), 32'd1);
    check_output("ar_pre_inflight", 32'(o_inflight), 32'd3);
    i_rst_n = 1'b0;
    #1;
    check_output("ar_flush", 32'(o_flush), 32'd0);
    check_output("ar_issue", 32'(o_issue), 32'd0);
    check_output("ar_stall", 32'(o_stall), 32'd0);
    check_output("ar_pending", o_pending, 32'd0);
    check_output("ar_inflight", 32'(o_inflight), 32'd0);
    #1 i_rst_n = 1'b1;
    #1;
    check_output("ar_post_issue", 32'(o_issue), 32'd1);
    check_output("ar_post_flush", 32'(o_flush), 32'd0);
    tick();
    idle_inputs();
    #1;
    check_output("ar_post_pending", o_pending, 32'h0000_2000);
    check_output("ar_post_inflight", 32'(o_inflight), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
